// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the MEM-stage access block.
package mem_stage_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_WORD: byte_en = 4'b1111;
            SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: byte_en = 4'b0001 << lane;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        sext16 = {{16{h[15]}}, h};
    endfunction

    function automatic logic [31:0] sext8(input logic [7:0] b);
        sext8 = {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_stage_access_lane.sv
// Combinational lane handling: store replication, byte enables, load extract/sign-extend.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    always_comb begin
        be = byte_en(size, lane);
        case (size)
            SZ_HALF: wdata = {2{wdata_in[15:0]}};
            SZ_BYTE: wdata = {4{wdata_in[7:0]}};
            default: wdata = wdata_in;
        endcase
        case (size)
            SZ_HALF: ld_data = sext16(lane[1] ? rdata[31:16] : rdata[15:0]);
            SZ_BYTE: ld_data = sext8(rdata[{lane, 3'b000} +: 8]);
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: sized dmem access over req/ack with timeout, stall generation, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN adds misaligned-access detection (MisalignErr_o).
module mem_stage_access
    import mem_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegWriteSig,
    input  logic        MemToRegSig,
    input  logic        MemToReg2Mux,
    input  logic [1:0]  MemReadSig,
    input  logic [1:0]  MemWriteSig,
    input  logic [31:0] ALUresult,
    input  logic [31:0] rdata2,
    input  logic [4:0]  regDstMux,
    input  logic [31:0] PC4,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        Stall_o,
    output logic        BusErr_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        MisalignErr_o,
`endif
    output logic        RegWriteSig_o,
    output logic        MemToRegSig_o,
    output logic        MemToReg2Mux_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUresult_o,
    output logic [31:0] PC4_o,
    output logic [4:0]  regDstMux_o
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wr_op, rd_op, op, mis, req, timeout, done;
    logic [1:0]       size;
    logic [31:0]      ld_data;

    assign wr_op = (MemWriteSig != SZ_NONE);
    assign rd_op = !wr_op && (MemReadSig != SZ_NONE);
    assign op    = wr_op || (MemReadSig != SZ_NONE);
    assign size  = wr_op ? MemWriteSig : MemReadSig;

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = op && (((size == SZ_WORD) && (ALUresult[1:0] != 2'b00)) ||
                        ((size == SZ_HALF) && ALUresult[0]));
`else
    assign mis = 1'b0;
`endif

    // A misaligned access is retired immediately without touching memory.
    assign req     = op && !mis && !Reset;
    assign timeout = (state == ST_WAIT) && (cnt == CNT_W'(ACK_TIMEOUT - 1)) && !dmem_ack;
    assign done    = req && (dmem_ack || timeout);
    assign Stall_o = op && !mis && !done;

    assign dmem_req  = req;
    assign dmem_we   = req && wr_op;
    assign dmem_addr = {ALUresult[31:2], 2'b00};

    mem_lane_align u_lane (
        .size     (size),
        .lane     (ALUresult[1:0]),
        .wdata_in (rdata2),
        .rdata    (dmem_rdata),
        .be       (dmem_be),
        .wdata    (dmem_wdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req && !dmem_ack) begin
                    state <= ST_WAIT;
                    cnt   <= CNT_W'(1);
                end
                ST_WAIT: if (dmem_ack || timeout) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            BusErr_o       <= 1'b0;
            RegWriteSig_o  <= 1'b0;
            MemToRegSig_o  <= 1'b0;
            MemToReg2Mux_o <= 1'b0;
            ReadData_o     <= '0;
            ALUresult_o    <= '0;
            PC4_o          <= '0;
            regDstMux_o    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            MisalignErr_o  <= 1'b0;
`endif
        end else begin
            if (timeout) BusErr_o <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
            MisalignErr_o <= mis;
`endif
            if (Stall_o) begin
                RegWriteSig_o <= 1'b0;
            end else begin
                RegWriteSig_o  <= RegWriteSig && !mis;
                MemToRegSig_o  <= MemToRegSig;
                MemToReg2Mux_o <= MemToReg2Mux;
                ReadData_o     <= (rd_op && req && dmem_ack) ? ld_data : 32'd0;
                ALUresult_o    <= ALUresult;
                PC4_o          <= PC4;
                regDstMux_o    <= regDstMux;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed self-checking bench for mem_stage_access (MEM_ALIGN_CHECK_EN optional).
module tb_mem_stage_access;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        RegWriteSig, MemToRegSig, MemToReg2Mux;
    logic [1:0]  MemReadSig, MemWriteSig;
    logic [31:0] ALUresult, rdata2, PC4;
    logic [4:0]  regDstMux;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        Stall_o, BusErr_o;
    logic        RegWriteSig_o, MemToRegSig_o, MemToReg2Mux_o;
    logic [31:0] ReadData_o, ALUresult_o, PC4_o;
    logic [4:0]  regDstMux_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic        MisalignErr_o;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    mem_stage_access dut (
        .Clk(Clk), .Reset(Reset),
        .RegWriteSig(RegWriteSig), .MemToRegSig(MemToRegSig), .MemToReg2Mux(MemToReg2Mux),
        .MemReadSig(MemReadSig), .MemWriteSig(MemWriteSig),
        .ALUresult(ALUresult), .rdata2(rdata2), .regDstMux(regDstMux), .PC4(PC4),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .Stall_o(Stall_o), .BusErr_o(BusErr_o),
`ifdef MEM_ALIGN_CHECK_EN
        .MisalignErr_o(MisalignErr_o),
`endif
        .RegWriteSig_o(RegWriteSig_o), .MemToRegSig_o(MemToRegSig_o),
        .MemToReg2Mux_o(MemToReg2Mux_o), .ReadData_o(ReadData_o),
        .ALUresult_o(ALUresult_o), .PC4_o(PC4_o), .regDstMux_o(regDstMux_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] alu,
                         input logic [31:0] sd, input logic rw, input logic ack,
                         input logic [31:0] rdat);
        MemReadSig  = rd;
        MemWriteSig = wr;
        ALUresult   = alu;
        rdata2      = sd;
        RegWriteSig = rw;
        dmem_ack    = ack;
        dmem_rdata  = rdat;
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        MemToRegSig = 1'b0; MemToReg2Mux = 1'b0;
        PC4 = 32'h0; regDstMux = 5'd0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(); step();
        Reset = 1'b0;
        chk("rst_rw", {31'd0, RegWriteSig_o}, 32'd0);
        chk("rst_alu", ALUresult_o, 32'd0);
        chk("rst_rd", ReadData_o, 32'd0);
        chk("rst_buserr", {31'd0, BusErr_o}, 32'd0);

        // plain ALU op
        PC4 = 32'h44; regDstMux = 5'd5; MemToReg2Mux = 1'b1;
        drive(2'b00, 2'b00, 32'h1234, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("alu_stall", {31'd0, Stall_o}, 32'd0);
        chk("alu_req", {31'd0, dmem_req}, 32'd0);
        step();
        chk("alu_res", ALUresult_o, 32'h1234);
        chk("alu_rw", {31'd0, RegWriteSig_o}, 32'd1);
        chk("alu_pc4", PC4_o, 32'h44);
        chk("alu_dst", {27'd0, regDstMux_o}, 32'd5);
        chk("alu_m2r2", {31'd0, MemToReg2Mux_o}, 32'd1);

        // word load, ack two cycles after req
        drive(2'b01, 2'b00, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wl_stall0", {31'd0, Stall_o}, 32'd1);
        chk("wl_req0", {31'd0, dmem_req}, 32'd1);
        chk("wl_addr0", dmem_addr, 32'h100);
        step();
        chk("wl_stall1", {31'd0, Stall_o}, 32'd1);
        chk("wl_addr1", dmem_addr, 32'h100);
        chk("wl_bubble", {31'd0, RegWriteSig_o}, 32'd0);
        step();
        chk("wl_bubble2", {31'd0, RegWriteSig_o}, 32'd0);
        drive(2'b01, 2'b00, 32'h100, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
        chk("wl_stall2", {31'd0, Stall_o}, 32'd0);
        step();
        chk("wl_data", ReadData_o, 32'hDEADBEEF);
        chk("wl_rw", {31'd0, RegWriteSig_o}, 32'd1);

        // zero-wait byte then half load, back to back
        drive(2'b11, 2'b00, 32'h103, 32'h0, 1'b1, 1'b1, 32'h80FFFFFF);
        chk("bl_stall", {31'd0, Stall_o}, 32'd0);
        chk("bl_req", {31'd0, dmem_req}, 32'd1);
        step();
        chk("bl_data", ReadData_o, 32'hFFFFFF80);
        drive(2'b10, 2'b00, 32'h102, 32'h0, 1'b1, 1'b1, 32'h7FFF0000);
        chk("hl_req", {31'd0, dmem_req}, 32'd1);
        step();
        chk("hl_data", ReadData_o, 32'h00007FFF);

        // timeout: no ack, abort in 16th cycle
        drive(2'b01, 2'b00, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int k = 1; k < 16; k++) begin
            chk($sformatf("to_stall%0d", k), {31'd0, Stall_o}, 32'd1);
            step();
        end
        chk("to_stall16", {31'd0, Stall_o}, 32'd0);
        chk("to_req16", {31'd0, dmem_req}, 32'd1);
        step();
        chk("to_buserr", {31'd0, BusErr_o}, 32'd1);
        chk("to_rdata", ReadData_o, 32'd0);

        // stores; write wins over read
        drive(2'b00, 2'b11, 32'h101, 32'h000000AB, 1'b0, 1'b0, 32'h0);
        chk("bs_we", {31'd0, dmem_we}, 32'd1);
        chk("bs_be", {28'd0, dmem_be}, 32'h2);
        chk("bs_wdata", dmem_wdata, 32'hABABABAB);
        drive(2'b00, 2'b11, 32'h101, 32'h000000AB, 1'b0, 1'b1, 32'h0);
        step();
        chk("buserr_sticky", {31'd0, BusErr_o}, 32'd1);
        drive(2'b00, 2'b10, 32'h102, 32'h00001234, 1'b0, 1'b1, 32'h0);
        chk("hs_be", {28'd0, dmem_be}, 32'hC);
        chk("hs_wdata", dmem_wdata, 32'h12341234);
        step();
        drive(2'b01, 2'b01, 32'h10, 32'hCAFEF00D, 1'b0, 1'b1, 32'h55555555);
        chk("ws_we", {31'd0, dmem_we}, 32'd1);
        chk("ws_be", {28'd0, dmem_be}, 32'hF);
        chk("ws_wdata", dmem_wdata, 32'hCAFEF00D);
        step();
        chk("ws_rdata", ReadData_o, 32'd0);

        // reset during WAIT
        drive(2'b01, 2'b00, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        chk("rw_stall", {31'd0, Stall_o}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("rw_req", {31'd0, dmem_req}, 32'd0);
        step();
        Reset = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rw_buserr", {31'd0, BusErr_o}, 32'd0);
        chk("rw_alu", ALUresult_o, 32'd0);
        chk("rw_pc4", PC4_o, 32'd0);
        chk("rw_m2r2", {31'd0, MemToReg2Mux_o}, 32'd0);
        chk("rw_stall_after", {31'd0, Stall_o}, 32'd0);

        // fresh zero-wait load after reset
        drive(2'b01, 2'b00, 32'h40, 32'h0, 1'b1, 1'b1, 32'h01020304);
        chk("fl_stall", {31'd0, Stall_o}, 32'd0);
        step();
        chk("fl_data", ReadData_o, 32'h01020304);

`ifdef MEM_ALIGN_CHECK_EN
        drive(2'b01, 2'b00, 32'h102, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("ma_req", {31'd0, dmem_req}, 32'd0);
        chk("ma_stall", {31'd0, Stall_o}, 32'd0);
        step();
        chk("ma_err", {31'd0, MisalignErr_o}, 32'd1);
        chk("ma_rw", {31'd0, RegWriteSig_o}, 32'd0);
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        chk("ma_pulse", {31'd0, MisalignErr_o}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage consumer of the EX/MEM register outputs.
- Performs sized load/store to data memory over a req/ack handshake, stalls the pipeline while memory is busy, and registers the MEM/WB stage outputs.
- Sits between the EX/MEM pipeline register and the write-back mux.

Parameters:
ACK_TIMEOUT, 16, cycles in WAIT without dmem_ack before the access is aborted (minimum 2).
CNT_W, 5, width of the timeout counter; must hold ACK_TIMEOUT.

Ports:
Clk  in  1  clock; all state updates on posedge.
Reset  in  1  synchronous, active-high.
RegWriteSig, MemToRegSig, MemToReg2Mux  in  1 each  control bits from EX/MEM.
MemReadSig, MemWriteSig  in  2 each  access size: 00 none, 01 word, 10 half, 11 byte.
ALUresult  in  32  effective address, or ALU result passed to WB.
rdata2  in  32  store data.
regDstMux  in  5  destination register.
PC4  in  32  link value, passed through.
dmem_req  out  1  access request.
dmem_we  out  1  1 = store.
dmem_addr  out  32  {ALUresult[31:2],2'b00}.
dmem_be  out  4  byte enables, little-endian.
dmem_wdata  out  32  lane-replicated store data.
dmem_ack  in  1  access complete; dmem_rdata valid this cycle.
dmem_rdata  in  32  load word.
Stall_o  out  1  hold PC/IF/ID/EX/MEM this cycle.
BusErr_o  out  1  sticky timeout flag.
RegWriteSig_o, MemToRegSig_o, MemToReg2Mux_o  out  1 each  MEM/WB control.
ReadData_o, ALUresult_o, PC4_o  out  32 each  MEM/WB data.
regDstMux_o  out  5  MEM/WB destination.

Behaviour:
- Reset: every output register is 0, FSM goes to IDLE, timeout counter is 0, BusErr_o is 0. dmem_req is gated low during the Reset cycle. Reset during WAIT abandons the access with no WB update.
- Operation: op = (MemWriteSig!=0) | (MemReadSig!=0). If both are non-zero, the write wins and the read is ignored.
- FSM has two states, IDLE and WAIT:
  - IDLE with op: dmem_req=1. If dmem_ack is 1 in the same cycle, the access completes (zero-wait). Otherwise go to WAIT.
  - WAIT: hold dmem_req=1 and all dmem_* outputs stable. Counter increments each cycle.
  - On dmem_ack, complete and return to IDLE.
  - If the counter reaches ACK_TIMEOUT-1 without ack: abort, set BusErr_o, ReadData_o=0, return to IDLE.
- Stall_o = op & !(completing this cycle). It is combinational, and upstream holds the EX/MEM inputs stable while it is high.
- MEM/WB register:
  - When Stall_o=0, all inputs are captured one cycle later. Non-memory instructions have 1-cycle latency.
  - When Stall_o=1, a bubble is written: RegWriteSig_o=0, other outputs hold.
- Store sizing:
  - word: be=1111, wdata=rdata2.
  - half: be=0011<<(2*addr[1]), wdata={2{rdata2[15:0]}}.
  - byte: be=0001<<addr[1:0], wdata={4{rdata2[7:0]}}.
- Load sizing: extract the addressed lane and sign-extend for half and byte. ReadData_o is registered on completion.
- Aborted store: no retry.
- BusErr_o: only Reset clears it.
- Back-to-back memory ops: the second op starts in the cycle after the first completes. There is no idle gap.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - Adds output MisalignErr_o (1 bit).
  - Misaligned accesses are: word with addr[1:0]!=0, or half with addr[0]=1.
  - For a misaligned access: no dmem_req is issued, no stall, MisalignErr_o pulses for 1 cycle aligned with the MEM/WB update, and RegWriteSig_o=0 for that instruction.
- Undefined: the port is absent. Low address bits not used for lane select are ignored (a word access is forced aligned; a half access uses addr[1] only).

Decomposition:
- Package mem_stage_pkg holds:
  - size encodings SZ_NONE/SZ_WORD/SZ_HALF/SZ_BYTE;
  - FSM state enum ST_IDLE/ST_WAIT;
  - functions for byte-enable generation and sign extension.
- One sub-module, mem_lane_align, is combinational store-lane replication, byte enables and load extraction/sign-extension. The FSM, counter and MEM/WB register stay in the top module.

Test Plan:
- ALU op, MemRead=MemWrite=00, ALUresult=0x1234, RegWrite=1 -> next cycle ALUresult_o=0x1234, RegWriteSig_o=1, Stall_o never high.
- Word load at 0x100, ack returned 2 cycles after req, rdata=0xDEADBEEF -> Stall_o high 2 cycles, dmem_addr=0x100 stable, ReadData_o=0xDEADBEEF after completion, bubble (RegWriteSig_o=0) during stall.
- Byte load at 0x103 with rdata=0x80FFFFFF, zero-wait ack -> no stall, ReadData_o=0xFFFFFF80. Half load at 0x102, rdata=0x7FFF0000 -> ReadData_o=0x00007FFF.
- Byte store at 0x101, rdata2=0x000000AB -> dmem_we=1, be=0010, wdata=0xABABABAB. Half store at 0x102 -> be=1100.
- Load with no ack for 16 cycles -> abort on the 16th cycle, BusErr_o=1 and stays 1, ReadData_o=0, Stall_o drops. Reset then clears BusErr_o.
- Reset asserted during WAIT -> dmem_req=0 in that cycle, all outputs 0 next cycle. With MEM_ALIGN_CHECK_EN, word load at 0x102 -> MisalignErr_o pulses, no dmem_req, RegWriteSig_o=0.
